// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared types for the register-file writeback arbiter: address width,
// the x0 address and the queued multi-cycle result entry.
package regfile_wb_arbiter_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int DATA_W     = 32;

    localparam logic [REG_ADDR_W-1:0] X0_ADDR = '0;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] waddr;
        logic [DATA_W-1:0]     wdata;
        logic                  live;
    } wb_entry_t;

endpackage

// File: rtl/regfile_wb_arbiter_fifo.sv
// Circular buffer of multi-cycle results with per-entry live bits, so a younger
// pipeline write can kill queued results to the same register without reordering.
module wb_result_fifo
    import regfile_wb_arbiter_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  push_i,
    input  wb_entry_t             push_entry_i,
    input  logic                  pop_i,
    input  logic                  kill_i,
    input  logic [REG_ADDR_W-1:0] kill_waddr_i,
    output wb_entry_t             head_o,
    output logic                  empty_o,
    output logic                  full_o,
    output logic                  any_live_o
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [PTR_W-1:0]      rd_ptr_q, wr_ptr_q;
    logic [PTR_W:0]        count_q;
    logic [DEPTH-1:0]      live_q, live_d;
    logic [REG_ADDR_W-1:0] waddr_q [DEPTH];
    logic [DATA_W-1:0]     wdata_q [DEPTH];

    assign empty_o    = (count_q == '0);
    assign full_o     = (count_q == (PTR_W+1)'(DEPTH));
    assign any_live_o = |live_q;
    assign head_o     = '{waddr: waddr_q[rd_ptr_q], wdata: wdata_q[rd_ptr_q], live: live_q[rd_ptr_q]};

    // Popped slots are cleared so live_q only ever marks occupied entries.
    always_comb begin
        // NOTE: assign every always_comb output a default first, otherwise paths that skip it infer a latch.
        live_d = live_q;
        if (kill_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (waddr_q[i] == kill_waddr_i) live_d[i] = 1'b0;
            end
        end
        if (pop_i)  live_d[rd_ptr_q] = 1'b0;
        if (push_i) live_d[wr_ptr_q] = push_entry_i.live;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
        if (!rst_n) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            live_q   <= '0;
        end else begin
            live_q <= live_d;
            if (push_i) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop_i)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({push_i, pop_i})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // NOTE: the payload array is deliberately not reset; live_q and count_q decide whether a slot means anything.
    always_ff @(posedge clk) begin
        if (push_i) begin
            waddr_q[wr_ptr_q] <= push_entry_i.waddr;
            wdata_q[wr_ptr_q] <= push_entry_i.wdata;
        end
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Shares the register-file write port between the in-order WB stage and queued
// multi-cycle results, with a starvation stall that guarantees the queue drains.
module regfile_wb_arbiter
    import regfile_wb_arbiter_pkg::*;
#(
    parameter int width    = DATA_W,
    parameter int DEPTH    = 2,
    parameter int MAX_WAIT = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  p_wen,
    input  logic [REG_ADDR_W-1:0] p_waddr,
    input  logic [width-1:0]      p_wdata,
    input  logic                  m_valid,
    output logic                  m_ready,
    input  logic [REG_ADDR_W-1:0] m_waddr,
    input  logic [width-1:0]      m_wdata,
    output logic                  rf_wen,
    output logic [REG_ADDR_W-1:0] rf_waddr,
    output logic [width-1:0]      rf_wdata,
    output logic                  stall_pipe,
    output logic                  m_busy
);

    localparam int                CNT_W     = 4;
    localparam logic [CNT_W-1:0]  LAST_WAIT = CNT_W'(MAX_WAIT - 1);

    logic             stall_q, stall_d;
    logic [CNT_W-1:0] wait_q, wait_d;
    wb_entry_t        head, push_entry;
    logic             empty, full, any_live;
    logic             p_grant, m_grant, push, pop;

    // rst_n gates the combinational grants so the port is quiet during reset.
    assign p_grant = rst_n && !stall_q && p_wen && (p_waddr != X0_ADDR);
    assign m_grant = rst_n && !p_grant && head.live;
    assign pop     = m_grant || (!empty && !head.live);

    assign m_ready    = rst_n && !full;
    assign push       = m_valid && m_ready && (m_waddr != X0_ADDR);
    assign push_entry = '{waddr: m_waddr, wdata: m_wdata, live: !(p_grant && (p_waddr == m_waddr))};

    assign stall_pipe = stall_q;
    assign m_busy     = any_live;

    wb_result_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk          (clk),
        .rst_n        (rst_n),
        .push_i       (push),
        .push_entry_i (push_entry),
        .pop_i        (pop),
        .kill_i       (p_grant),
        .kill_waddr_i (p_waddr),
        .head_o       (head),
        .empty_o      (empty),
        .full_o       (full),
        .any_live_o   (any_live)
    );

    always_comb begin
        rf_wen   = 1'b0;
        rf_waddr = '0;
        rf_wdata = '0;
        if (p_grant) begin
            rf_wen   = 1'b1;
            rf_waddr = p_waddr;
            rf_wdata = p_wdata;
        end else if (m_grant) begin
            rf_wen   = 1'b1;
            rf_waddr = head.waddr;
            rf_wdata = head.wdata;
        end
    end

    // The stall cycle itself never counts, so stall_pipe cannot assert back to back.
    always_comb begin
        stall_d = 1'b0;
        wait_d  = '0;
        if (!stall_q && head.live && !m_grant) begin
            if (wait_q == LAST_WAIT) stall_d = 1'b1;
            else                     wait_d  = wait_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_q <= 1'b0;
            wait_q  <= '0;
        end else begin
            stall_q <= stall_d;
            wait_q  <= wait_d;
        end
    end

endmodule
